// File: rtl/i2c_disp_pkg.sv
// Shared types and constants for the EEPROM read-back display.
//   SEG_OFF      : all segments dark (active-low pattern)
//   SEG_DASH     : only segment g lit, shown on every digit while the history is empty
//   NUM_DIGITS   : digits on the multiplexed display
//   hist_entry_t : one captured read, {addr, data}
//   scan_state_e : display scan FSM states
//   next_digit() : scan order 5,4,...,0,5
package i2c_disp_pkg;

  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [7:0]  SEG_DASH   = 8'hBF;
  localparam int unsigned NUM_DIGITS = 6;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } hist_entry_t;

  typedef enum logic [0:0] {
    StIdle,
    StScan
  } scan_state_e;

  // Digit index steps down from the leftmost digit and wraps back to it.
  function automatic logic [2:0] next_digit(input logic [2:0] digit);
    return (digit == 3'd0) ? 3'(NUM_DIGITS - 1) : digit - 3'd1;
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to 7-segment decoder for a common-anode display.
// Ports:
//   nibble : 4-bit hex value
//   seg_n  : segments {g,f,e,d,c,b,a}, active-low
module seg7_hex_dec (
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = 7'h7F;
    unique case (nibble)
      4'h0: seg_n = 7'h40;
      4'h1: seg_n = 7'h79;
      4'h2: seg_n = 7'h24;
      4'h3: seg_n = 7'h30;
      4'h4: seg_n = 7'h19;
      4'h5: seg_n = 7'h12;
      4'h6: seg_n = 7'h02;
      4'h7: seg_n = 7'h78;
      4'h8: seg_n = 7'h00;
      4'h9: seg_n = 7'h10;
      4'hA: seg_n = 7'h08;
      4'hB: seg_n = 7'h03;
      4'hC: seg_n = 7'h46;
      4'hD: seg_n = 7'h21;
      4'hE: seg_n = 7'h06;
      4'hF: seg_n = 7'h0E;
      default: seg_n = 7'h7F;
    endcase
  end

endmodule

// File: rtl/i2c_rd_seg_disp.sv
// EEPROM read-back display. Every byte returned by the I2C controller is stored with
// its word address in a 4-entry history. One entry is shown as AAAA.DD (hex) on a
// 6-digit multiplexed 7-segment display; view_step walks back through older entries.
//
// Ports:
//   clk       : system clock
//   rst       : asynchronous, active-high reset
//   rd_valid  : one-cycle strobe, rd_data/byte_addr valid
//   rd_data   : byte read from the EEPROM
//   byte_addr : address of that byte
//   view_step : one-cycle debounced key pulse, show the next-older entry
//   seg       : segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   sel       : digit enables, active-low, sel[5] = leftmost digit, registered
//
// Build option:
//   LEAD_ZERO_BLANK_EN : blank leading zero nibbles of the address on digits 5..3.
module i2c_rd_seg_disp
  import i2c_disp_pkg::*;
#(
  parameter logic [15:0] CNT_SCAN_MAX = 16'd49_999,
  parameter logic [2:0]  HIST_DEPTH   = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  input  logic [15:0] byte_addr,
  input  logic        view_step,
  output logic [7:0]  seg,
  output logic [5:0]  sel
);

  // ---------------------------------------------------------------------------
  // History buffer
  // ---------------------------------------------------------------------------
  hist_entry_t hist_q [4];
  logic [1:0]  wr_ptr_q;
  logic [2:0]  count_q;
  logic [1:0]  view_q;

  // A capture takes priority over a simultaneous step and always snaps back
  // to the newest entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        hist_q[i] <= '0;
      end
      wr_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      view_q   <= 2'd0;
    end else if (rd_valid) begin
      hist_q[wr_ptr_q] <= '{addr: byte_addr, data: rd_data};
      wr_ptr_q         <= wr_ptr_q + 2'd1;
      if (count_q != HIST_DEPTH) begin
        count_q <= count_q + 3'd1;
      end
      view_q <= 2'd0;
    end else if (view_step && (count_q != 3'd0)) begin
      view_q <= (view_q == 2'(count_q - 3'd1)) ? 2'd0 : view_q + 2'd1;
    end
  end

  // Newest entry sits just behind wr_ptr; view counts backwards from it (mod 4).
  logic [1:0]  rd_idx;
  hist_entry_t shown;

  assign rd_idx = wr_ptr_q - 2'd1 - view_q;
  assign shown  = hist_q[rd_idx];

  // ---------------------------------------------------------------------------
  // Digit content
  // ---------------------------------------------------------------------------
  logic [2:0] digit_q;
  logic [3:0] nibble;
  logic [6:0] hex_seg_n;
  logic [7:0] seg_next;

  always_comb begin
    nibble = 4'h0;
    case (digit_q)
      3'd5:    nibble = shown.addr[15:12];
      3'd4:    nibble = shown.addr[11:8];
      3'd3:    nibble = shown.addr[7:4];
      3'd2:    nibble = shown.addr[3:0];
      3'd1:    nibble = shown.data[7:4];
      3'd0:    nibble = shown.data[3:0];
      default: nibble = 4'h0;
    endcase
  end

  seg7_hex_dec u_hex_dec (
    .nibble (nibble),
    .seg_n  (hex_seg_n)
  );

`ifdef LEAD_ZERO_BLANK_EN
  // Each address digit is blank only if it and every digit to its left are zero.
  logic zero5, zero4, zero3;
  logic blank;

  assign zero5 = (shown.addr[15:12] == 4'h0);
  assign zero4 = zero5 && (shown.addr[11:8] == 4'h0);
  assign zero3 = zero4 && (shown.addr[7:4] == 4'h0);

  always_comb begin
    blank = 1'b0;
    case (digit_q)
      3'd5:    blank = zero5;
      3'd4:    blank = zero4;
      3'd3:    blank = zero3;
      default: blank = 1'b0;
    endcase
  end
`endif

  // The decimal point separates address from data, so it sits on digit 2.
  always_comb begin
    seg_next = {(digit_q != 3'd2), hex_seg_n};
    if (count_q == 3'd0) begin
      seg_next = SEG_DASH;
    end
`ifdef LEAD_ZERO_BLANK_EN
    else if (blank) begin
      seg_next = SEG_OFF;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Scan FSM and output registers
  // ---------------------------------------------------------------------------
  scan_state_e state_q;
  logic [15:0] cnt_q;
  logic        load_q;

  // load_q marks the cycle after a digit change: outputs are refreshed only then,
  // so a slot never changes content part-way through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      digit_q <= 3'd0;
      load_q  <= 1'b0;
      seg     <= SEG_OFF;
      sel     <= 6'h3F;
    end else begin
      case (state_q)
        StIdle: begin
          state_q <= StScan;
          cnt_q   <= 16'd0;
          load_q  <= 1'b0;
        end
        StScan: begin
          if (cnt_q == CNT_SCAN_MAX) begin
            cnt_q   <= 16'd0;
            digit_q <= next_digit(digit_q);
            load_q  <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + 16'd1;
            load_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          load_q  <= 1'b0;
        end
      endcase

      if (load_q) begin
        seg <= seg_next;
        sel <= ~(6'b00_0001 << digit_q);
      end
    end
  end

endmodule

// File: tb/tb_i2c_rd_seg_disp.sv
// Self-checking bench for i2c_rd_seg_disp with a fast scan (CNT_SCAN_MAX = 3).
// The reference model keeps the history as a newest-first queue of {addr,data}
// words and derives each expected digit from the shown word directly.
// Build option mirrored from the design: LEAD_ZERO_BLANK_EN.
module tb_i2c_rd_seg_disp;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [15:0] byte_addr;
  logic        view_step;
  logic [7:0]  seg;
  logic [5:0]  sel;

  int checks   = 0;
  int failures = 0;

  // Reference model: newest entry at index 0.
  logic [23:0] model_q [$];
  int          view_m = 0;

  // Common-anode hex font with dp off.
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clk = ~clk;

  i2c_rd_seg_disp #(
    .CNT_SCAN_MAX (16'd3),
    .HIST_DEPTH   (3'd4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .byte_addr (byte_addr),
    .view_step (view_step),
    .seg       (seg),
    .sel       (sel)
  );

  function automatic logic [7:0] exp_seg(input int k);
    logic [23:0] w;
    logic [15:0] a;
    logic [3:0]  n;
    logic [7:0]  s;
    if (model_q.size() == 0) return 8'hBF;
    w = model_q[view_m];
    a = w[23:8];
`ifdef LEAD_ZERO_BLANK_EN
    if (k >= 3 && (a >> (4 * (k - 2))) == 16'd0) return 8'hFF;
`endif
    n = 4'(w >> (4 * k));
    s = font[n];
    if (k == 2) s[7] = 1'b0;
    return s;
  endfunction

  function automatic int sel_digit(input logic [5:0] s);
    int n = 0;
    int k = -1;
    for (int i = 0; i < 6; i++) begin
      if (!s[i]) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  task automatic drive(input logic rv, input logic vs, input logic [15:0] a,
                       input logic [7:0] d);
    @(negedge clk);
    rd_valid  = rv;
    view_step = vs;
    byte_addr = a;
    rd_data   = d;
    @(negedge clk);
    rd_valid  = 1'b0;
    view_step = 1'b0;
    if (rv) begin
      model_q.push_front({a, d});
      if (model_q.size() > 4) void'(model_q.pop_back());
      view_m = 0;
    end else if (vs && model_q.size() > 0) begin
      view_m = (view_m == model_q.size() - 1) ? 0 : view_m + 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_q.delete();
    view_m = 0;
  endtask

  task automatic wait_sel_change(input string tag, output bit ok);
    logic [5:0] prev;
    prev = sel;
    ok   = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (sel !== prev) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s slot timeout: sel=%h stuck, required a change within 64 cycles",
               tag, sel);
    end
  endtask

  // Skips one slot boundary (it may carry pre-update content), then checks a full
  // frame of six slots: scan order, single active digit and segment pattern.
  task automatic check_frame(input string tag);
    bit         ok;
    int         prev_k;
    int         exp_k;
    logic [5:0] exp_sel;
    logic [7:0] exp_s;
    wait_sel_change(tag, ok);
    if (!ok) return;
    prev_k = sel_digit(sel);
    checks++;
    if (prev_k < 0) begin
      failures++;
      $display("FAIL %s sel one-hot: got %h, required exactly one low bit", tag, sel);
      return;
    end
    for (int s = 0; s < 6; s++) begin
      wait_sel_change(tag, ok);
      if (!ok) return;
      exp_k   = (prev_k == 0) ? 5 : prev_k - 1;
      exp_sel = ~(6'b00_0001 << exp_k);
      exp_s   = exp_seg(exp_k);
      checks++;
      if (sel !== exp_sel) begin
        failures++;
        $display("FAIL %s sel order: got %h, required %h", tag, sel, exp_sel);
      end
      checks++;
      if (seg !== exp_s) begin
        failures++;
        $display("FAIL %s seg d%0d: got %h, required %h", tag, exp_k, seg, exp_s);
      end
      prev_k = exp_k;
    end
  endtask

  task automatic test_reset();
    bit ok;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset seg: got %h, required ff", seg);
    end
    checks++;
    if (sel !== 6'h3F) begin
      failures++;
      $display("FAIL reset sel: got %h, required 3f", sel);
    end
    rst = 1'b0;
    wait_sel_change("first_slot", ok);
    if (ok) begin
      checks++;
      if (sel !== 6'h1F || seg !== 8'hBF) begin
        failures++;
        $display("FAIL first_slot: got sel=%h seg=%h, required sel=1f seg=bf", sel, seg);
      end
    end
    check_frame("empty_after_reset");
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 16'h0012, 8'hA5);
    check_frame("single_0012_a5");
  endtask

  task automatic test_history();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 16'(i), 8'($urandom));
    end
    check_frame("hist_newest");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h0, 8'h0);
      check_frame("hist_step");
    end
  endtask

  task automatic test_empty_and_collide();
    do_reset();
    drive(1'b0, 1'b1, 16'h0, 8'h0);
    check_frame("step_when_empty");
    drive(1'b1, 1'b0, 16'hBEEF, 8'h11);
    drive(1'b1, 1'b0, 16'hC0DE, 8'h22);
    drive(1'b0, 1'b1, 16'h0, 8'h0);
    check_frame("older_view");
    drive(1'b1, 1'b1, 16'h9A3C, 8'h5E);
    check_frame("capture_beats_step");
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    drive(1'b1, 1'b0, 16'h4321, 8'h87);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sel === 6'h37) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL reset_mid: got sel=%h, required d3 (37) within 100 cycles", sel);
    end else begin
      #2 rst = 1'b1;
      #1;
      checks++;
      if (seg !== 8'hFF || sel !== 6'h3F) begin
        failures++;
        $display("FAIL reset_mid async: got seg=%h sel=%h, required ff/3f", seg, sel);
      end
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      view_m = 0;
      check_frame("after_mid_reset");
    end
  endtask

  task automatic test_lead_zero();
    drive(1'b1, 1'b0, 16'h0007, 8'h00);
    check_frame("lead_zero_0007");
    drive(1'b1, 1'b0, 16'h00A0, 8'h3C);
    check_frame("lead_zero_00a0");
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 20; i++) begin
      a = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      drive(1'($urandom), 1'($urandom), a, 8'($urandom));
      check_frame("random");
    end
  endtask

  initial begin
    rst       = 1'b1;
    rd_valid  = 1'b0;
    view_step = 1'b0;
    rd_data   = 8'h00;
    byte_addr = 16'h0000;
    test_reset();
    test_single();
    test_history();
    test_empty_and_collide();
    test_reset_mid();
    test_lead_zero();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
